ssp_uart_tx_chan: RTL and testbench
===================================

Name: ssp_uart_tx_chan

Overview:
Parametrised UART transmit channel: the next generation of the SSP_UART transmit path, generalised in data width and FIFO depth. It adds selectable parity, 1/2 stop bits, CTS flow control and an RS-485 drive-enable guard time. It sits between the SSP register decode (write strobe into the Tx FIFO) and the RS-232/RS-485 line drivers. A companion receive channel is a separate block.

Parameters:
pDataW, 8, character width in bits, legal 5..9
pTF_Depth, 4, Tx FIFO depth = 2**pTF_Depth entries; 0 = single holding register
pBaudW, 16, width of baud divisor input

Ports:
Clk  input  1  system clock
Rst  input  1  asynchronous active-low reset
WE  input  1  FIFO write strobe, one character per cycle
DI  input  pDataW  write data
BaudDiv  input  pBaudW  bit time = BaudDiv+1 Clk cycles
Parity  input  2  00 none, 01 odd, 10 even, 11 mark (parity bit = 1)
Stop2  input  1  1 = two stop bits
CTSEn  input  1  enable xCTS flow control
xCTS  input  1  active-low clear-to-send
Mode485  input  1  1 = RS-485 (xDE used, guard time applied)
IE  input  1  empty-interrupt enable
ClrErr  input  1  clears Ovr
TxD  output  1  serial data, idle high
xDE  output  1  RS-485 transceiver drive enable, active-high
Full  output  1  FIFO full
FCnt  output  pTF_Depth+1  FIFO occupancy, 0..2**pTF_Depth
Ovr  output  1  sticky: write attempted while full
TxIdle  output  1  FSM in IDLE and FIFO empty
IRQ  output  1  IE & FIFO empty, registered

Behaviour:
- Reset (Rst=0, asynchronous): TxD=1, xDE=0, Full=0, FCnt=0, Ovr=0, TxIdle=1, IRQ=0, FSM=IDLE, FIFO pointers=0.
- FIFO: write when WE & !Full; WE & Full drops the data and sets Ovr on the next edge. Ovr clears on ClrErr; if a set and ClrErr coincide, the set wins.
- Pop and write in the same cycle while full is legal: FCnt is unchanged, both take effect. Pointers wrap modulo 2**pTF_Depth.
- FSM states: IDLE, START, DATA, PARITY, STOP, GUARD.
- IDLE: if FIFO non-empty and (!CTSEn | !xCTS), pop the head into the shift register, clear the bit counter and enter START. TxD=0 from the next edge. xDE=Mode485 from the same edge.
- Bit timer: loaded with BaudDiv on each state/bit entry; a bit ends when the timer reaches 0, so every bit lasts BaudDiv+1 cycles.
- DATA: pDataW bits, LSB first. Parity is the XOR of the data bits: odd inverts it, mark forces 1. The PARITY state is skipped when Parity=00.
- STOP: TxD=1 for 1 bit, or 2 if Stop2.
- After STOP: if Mode485, enter GUARD for 1 bit time with TxD=1 and xDE=1, then IDLE with xDE=0; otherwise go directly to IDLE.
- Back-to-back frames: from IDLE with data available, START begins on the cycle after STOP/GUARD ends, with no idle gap.
- CTS is sampled only in IDLE. Deasserting xCTS mid-frame never truncates the current frame.
- BaudDiv, Parity, Stop2 and Mode485 are sampled at frame start (START entry) and held for the whole frame.
- Rst asserted mid-frame aborts the frame immediately; TxD returns to 1 and the FIFO is flushed.
- pTF_Depth=0: Full=1 whenever the holding register is occupied. The holding register frees on the pop into the shift register, so a second write is accepted during transmission.

Decomposition:
- Package ssp_uart_pkg: state typedef (tx_state_t), parity encoding constants (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK).
- One sub-module: ssp_uart_fifo (parametrised pDataW/pTF_Depth synchronous FIFO with FCnt/Full/Empty), reusable by the receive channel.

Test Plan:
- Reset mid-frame: BaudDiv=3, 8N1, write 0xA5 -> TxD per bit (4 clk each) 0,1,0,1,0,0,1,0,1,1; frame is 40 clocks; TxIdle returns to 1. Assert Rst in bit 3 of a repeat frame -> TxD=1, FCnt=0 immediately.
- Parity/stop: even parity, Stop2=1, 0xA5 -> parity bit 0, two stop bits, frame 48 clocks. Odd parity -> parity bit 1. Mark -> parity bit 1.
- FIFO fill: pTF_Depth=2, BaudDiv=0, CTSEn=1, xCTS=1, five writes -> FCnt=4, Full=1, Ovr=1, no transmission. ClrErr -> Ovr=0. Drop xCTS to 0 -> four back-to-back frames with no idle gap. IRQ rises with IE=1 when FCnt hits 0.
- CTS mid-frame: raise xCTS during DATA -> current frame completes; the next queued frame waits until xCTS=0.
- RS-485: Mode485=1, BaudDiv=1 -> xDE rises on the same edge as the start bit and falls 2 clocks after the last stop bit ends.
- Depth 0 / pDataW=9: pTF_Depth=0, pDataW=9, write 0x1FF then 0x000 immediately -> second write accepted after the pop; frames 0,1×9,1 and 0,0×9,1.

Source files
------------

// File: rtl/ssp_uart_pkg.sv
// Shared types and constants for the SSP UART channels.
//   tx_state_t : transmit FSM state encoding
//   PAR_*      : encoding of the 2-bit Parity control input
package ssp_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GUARD  = 3'd5
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

endpackage

// File: rtl/ssp_uart_fifo.sv
// Synchronous FIFO of 2**pTF_Depth entries (pTF_Depth = 0 gives a single
// holding register). A write while full is accepted only if a pop happens in
// the same cycle; otherwise it is dropped (the caller flags overrun).
//   Clk, Rst    : clock, asynchronous active-low reset (flushes pointers)
//   wr_en_i     : write strobe,  wr_data_i : write data
//   rd_en_i     : pop strobe (ignored while empty), rd_data_o : head entry
//   cnt_o       : occupancy 0..2**pTF_Depth, full_o / empty_o : status
module ssp_uart_fifo #(
    parameter int pDataW    = 8,
    parameter int pTF_Depth = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 wr_en_i,
    input  logic [pDataW-1:0]    wr_data_i,
    input  logic                 rd_en_i,
    output logic [pDataW-1:0]    rd_data_o,
    output logic [pTF_Depth:0]   cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int DEPTH = 1 << pTF_Depth;
    // Pointers need at least one bit; at depth 1 they simply stay at zero.
    localparam int PW    = (pTF_Depth > 0) ? pTF_Depth : 1;
    localparam int CW    = pTF_Depth + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [pDataW-1:0] mem_q [1 << PW];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_s, empty_s, push_s, pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    assign full_s  = (cnt_q == FULL_CNT);
    assign empty_s = (cnt_q == {CW{1'b0}});
    assign pop_s   = rd_en_i & ~empty_s;
    // A pop in the same cycle frees the slot the write needs.
    assign push_s  = wr_en_i & (~full_s | pop_s);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign cnt_o     = cnt_q;
    assign full_o    = full_s;
    assign empty_o   = empty_s;

endmodule

// File: rtl/ssp_uart_tx_chan.sv
// UART transmit channel: Tx FIFO plus serialiser with selectable parity,
// 1/2 stop bits, CTS flow control and RS-485 drive-enable guard time.
//   Clk, Rst (async active-low), WE/DI : FIFO write port
//   BaudDiv : bit time = BaudDiv+1 clocks; Parity/Stop2/Mode485 : frame format
//   CTSEn/xCTS : flow control, checked only before a frame starts
//   IE/ClrErr  : empty-interrupt enable, overrun clear
//   TxD, xDE, Full, FCnt, Ovr, TxIdle, IRQ : line and status outputs
module ssp_uart_tx_chan
    import ssp_uart_pkg::*;
#(
    parameter int pDataW    = 8,
    parameter int pTF_Depth = 4,
    parameter int pBaudW    = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 WE,
    input  logic [pDataW-1:0]    DI,
    input  logic [pBaudW-1:0]    BaudDiv,
    input  logic [1:0]           Parity,
    input  logic                 Stop2,
    input  logic                 CTSEn,
    input  logic                 xCTS,
    input  logic                 Mode485,
    input  logic                 IE,
    input  logic                 ClrErr,
    output logic                 TxD,
    output logic                 xDE,
    output logic                 Full,
    output logic [pTF_Depth:0]   FCnt,
    output logic                 Ovr,
    output logic                 TxIdle,
    output logic                 IRQ
);

    localparam int BCW = 4;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(pDataW - 1);

    tx_state_t           state_q, state_d;
    logic [pBaudW-1:0]   timer_q, timer_d;
    logic [pBaudW-1:0]   baud_q, baud_d;
    logic [BCW-1:0]      bitcnt_q, bitcnt_d;
    logic [pDataW-1:0]   shreg_q, shreg_d;
    logic [1:0]          par_mode_q, par_mode_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                m485_q, m485_d;
    logic                txd_q, txd_d;
    logic                xde_q, xde_d;
    logic                ovr_q, ovr_d;
    logic                irq_q, irq_d;

    logic                pop_s, start_s, can_start_s, bit_end_s, drop_s;
    logic [pDataW-1:0]   head_s;
    logic                full_s, empty_s;

    function automatic logic calc_parity(input logic [pDataW-1:0] d,
                                         input logic [1:0] mode);
        logic r;
        case (mode)
            PAR_ODD:  r = ~(^d);
            PAR_EVEN: r = ^d;
            PAR_MARK: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    ssp_uart_fifo #(
        .pDataW    (pDataW),
        .pTF_Depth (pTF_Depth)
    ) u_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .wr_en_i   (WE),
        .wr_data_i (DI),
        .rd_en_i   (pop_s),
        .rd_data_o (head_s),
        .cnt_o     (FCnt),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    assign can_start_s = ~empty_s & (~CTSEn | ~xCTS);
    assign bit_end_s   = (timer_q == {pBaudW{1'b0}});
    // Matches the FIFO accept rule: a write while full survives only with a pop.
    assign drop_s      = WE & full_s & ~pop_s;

    // FSM next-state, bit timing and line drive.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        baud_d     = baud_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        m485_d     = m485_q;
        txd_d      = txd_q;
        xde_d      = xde_q;
        start_s    = 1'b0;
        pop_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d   = 1'b1;
                xde_d   = 1'b0;
                start_s = can_start_s;
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d  = ST_DATA;
                    timer_d  = baud_q;
                    bitcnt_d = {BCW{1'b0}};
                    txd_d    = shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[pDataW-1:1]};
                end else begin
                    timer_d = timer_q - pBaudW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    timer_d = baud_q;
                    if (bitcnt_q == LAST_BIT) begin
                        if (par_mode_q != PAR_NONE) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d  = ST_STOP;
                            txd_d    = 1'b1;
                            bitcnt_d = {BCW{1'b0}};
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                        txd_d    = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[pDataW-1:1]};
                    end
                end else begin
                    timer_d = timer_q - pBaudW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d  = ST_STOP;
                    timer_d  = baud_q;
                    txd_d    = 1'b1;
                    bitcnt_d = {BCW{1'b0}};
                end else begin
                    timer_d = timer_q - pBaudW'(1);
                end
            end
            ST_STOP: begin
                // bitcnt counts stop bits already sent.
                if (bit_end_s) begin
                    if (stop2_q && (bitcnt_q == {BCW{1'b0}})) begin
                        bitcnt_d = BCW'(1);
                        timer_d  = baud_q;
                    end else if (m485_q) begin
                        state_d = ST_GUARD;
                        timer_d = baud_q;
                        txd_d   = 1'b1;
                        xde_d   = 1'b1;
                    end else begin
                        // Chain straight into the next start bit when possible.
                        state_d = ST_IDLE;
                        xde_d   = 1'b0;
                        start_s = can_start_s;
                    end
                end else begin
                    timer_d = timer_q - pBaudW'(1);
                end
            end
            ST_GUARD: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    xde_d   = 1'b0;
                    start_s = can_start_s;
                end else begin
                    timer_d = timer_q - pBaudW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                xde_d   = 1'b0;
            end
        endcase

        // Frame start: pop the head and latch the format for the whole frame.
        if (start_s) begin
            pop_s      = 1'b1;
            state_d    = ST_START;
            shreg_d    = head_s;
            txd_d      = 1'b0;
            xde_d      = Mode485;
            timer_d    = BaudDiv;
            baud_d     = BaudDiv;
            bitcnt_d   = {BCW{1'b0}};
            par_mode_d = Parity;
            par_bit_d  = calc_parity(head_s, Parity);
            stop2_d    = Stop2;
            m485_d     = Mode485;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sticky overrun (a new overrun beats a clear) and empty interrupt.
    always_comb begin
        irq_d = IE & empty_s;
        if (drop_s) begin
            ovr_d = 1'b1;
        end else if (ClrErr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // FSM, datapath and status registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= {pBaudW{1'b0}};
            baud_q     <= {pBaudW{1'b0}};
            bitcnt_q   <= {BCW{1'b0}};
            shreg_q    <= {pDataW{1'b0}};
            par_mode_q <= PAR_NONE;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            m485_q     <= 1'b0;
            txd_q      <= 1'b1;
            xde_q      <= 1'b0;
            ovr_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            baud_q     <= baud_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_mode_q <= par_mode_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            m485_q     <= m485_d;
            txd_q      <= txd_d;
            xde_q      <= xde_d;
            ovr_q      <= ovr_d;
            irq_q      <= irq_d;
        end
    end

    assign TxD    = txd_q;
    assign xDE    = xde_q;
    assign Full   = full_s;
    assign Ovr    = ovr_q;
    assign IRQ    = irq_q;
    assign TxIdle = (state_q == ST_IDLE) & empty_s;

endmodule

// File: tb/tb_ssp_uart_tx_chan.sv
// Directed bench for ssp_uart_tx_chan: an 8-bit/4-deep instance and a
// 9-bit/single-register instance. Expected line bits are queued when a
// character is written and popped as the serial line is sampled.
module tb_ssp_uart_tx_chan;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, stop2, ctsen, xcts, m485, ie, clrerr;
    logic [7:0]  di;
    logic [15:0] baud;
    logic [1:0]  par;
    logic        txd, xde, full, ovr, txidle, irq;
    logic [2:0]  fcnt;

    logic        b_we;
    logic [8:0]  b_di;
    logic [15:0] b_baud;
    logic        txd9, xde9, full9, ovr9, txidle9, irq9;
    logic [0:0]  fcnt9;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc;
    logic xde_at_start;
    logic exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ssp_uart_tx_chan #(.pDataW(8), .pTF_Depth(2), .pBaudW(16)) dut (
        .Clk(clk), .Rst(rst), .WE(we), .DI(di), .BaudDiv(baud), .Parity(par),
        .Stop2(stop2), .CTSEn(ctsen), .xCTS(xcts), .Mode485(m485), .IE(ie),
        .ClrErr(clrerr), .TxD(txd), .xDE(xde), .Full(full), .FCnt(fcnt),
        .Ovr(ovr), .TxIdle(txidle), .IRQ(irq)
    );

    ssp_uart_tx_chan #(.pDataW(9), .pTF_Depth(0), .pBaudW(16)) dut9 (
        .Clk(clk), .Rst(rst), .WE(b_we), .DI(b_di), .BaudDiv(b_baud), .Parity(par),
        .Stop2(stop2), .CTSEn(ctsen), .xCTS(xcts), .Mode485(m485), .IE(ie),
        .ClrErr(clrerr), .TxD(txd9), .xDE(xde9), .Full(full9), .FCnt(fcnt9),
        .Ovr(ovr9), .TxIdle(txidle9), .IRQ(irq9)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [8:0] d, input int nd,
                              input logic [1:0] pm, input bit s2);
        logic x;
        x = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            exp_q.push_back(d[i]);
            x = x ^ d[i];
        end
        if (pm == 2'b01)      exp_q.push_back(~x);
        else if (pm == 2'b10) exp_q.push_back(x);
        else if (pm == 2'b11) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        we = 1'b1;
        di = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_start(input int which, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (((which != 0) ? txd9 : txd) === 1'b0) seen = 1'b1;
        end
        start_cyc    = cyc;
        xde_at_start = xde;
    endtask

    // Sample nbits line bits at bt-clock spacing; optionally raise xCTS at a bit.
    task automatic check_frame(input string tag, input int which, input int bt,
                               input int nbits, input int cts_bit);
        bit   seen;
        logic e;
        wait_start(which, seen);
        chk({tag, "_start"}, 32'(seen), 32'd1);
        if (seen) begin
            repeat ((bt - 1) / 2) @(negedge clk);
            for (int b = 0; b < nbits; b++) begin
                if (b > 0) repeat (bt) @(negedge clk);
                if (b == cts_bit) xcts = 1'b1;
                e = exp_q.pop_front();
                chk($sformatf("%s_bit%0d", tag, b), 32'((which != 0) ? txd9 : txd), 32'(e));
            end
        end else begin
            exp_q.delete();
        end
    endtask

    // Clocks from start-bit edge until TxIdle is seen again.
    task automatic check_len(input string tag, input int exp_len);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (txidle === 1'b1) seen = 1'b1;
        end
        chk(tag, seen ? 32'(cyc - start_cyc) : 32'hFFFF_FFFF, 32'(exp_len));
    endtask

    initial begin
        logic [7:0] v5 [5];
        bit         seen;
        v5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst = 1'b0; we = 1'b0; di = 8'h00; baud = 16'd3; par = 2'b00;
        stop2 = 1'b0; ctsen = 1'b0; xcts = 1'b0; m485 = 1'b0; ie = 1'b0;
        clrerr = 1'b0; b_we = 1'b0; b_di = 9'h000; b_baud = 16'd1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_xde", 32'(xde), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_fcnt", 32'(fcnt), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_txidle", 32'(txidle), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst9_txd", 32'({txd9, xde9, irq9, txidle9}), 32'b1001);
        rst = 1'b1;

        // 8N1 0xA5 at 4 clocks/bit, 40-clock frame
        push_frame(9'h0A5, 8, 2'b00, 1'b0);
        wr(8'hA5);
        check_frame("a5_8n1", 0, 4, 10, -1);
        check_len("a5_len", 40);

        // Reset in bit 3 of a repeat frame, second char queued behind it
        wr(8'hA5);
        wr(8'h5A);
        wait_start(0, seen);
        chk("rst_mid_start", 32'(seen), 32'd1);
        repeat (13) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_fcnt", 32'(fcnt), 32'd0);
        chk("rst_mid_txidle", 32'(txidle), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Even parity with two stop bits, then odd and mark
        par = 2'b10; stop2 = 1'b1;
        push_frame(9'h0A5, 8, 2'b10, 1'b1);
        wr(8'hA5);
        check_frame("a5_e2", 0, 4, 12, -1);
        check_len("a5_e2_len", 48);
        par = 2'b01; stop2 = 1'b0;
        push_frame(9'h0A5, 8, 2'b01, 1'b0);
        wr(8'hA5);
        check_frame("a5_o1", 0, 4, 11, -1);
        check_len("a5_o1_len", 44);
        par = 2'b11;
        push_frame(9'h0A5, 8, 2'b11, 1'b0);
        wr(8'hA5);
        check_frame("a5_m1", 0, 4, 11, -1);
        check_len("a5_m1_len", 44);

        // FIFO fill behind CTS, overrun, clear, then burst drain
        par = 2'b00; baud = 16'd0; ctsen = 1'b1; xcts = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            we = 1'b1;
            di = v5[i];
        end
        @(negedge clk);
        we = 1'b0;
        chk("fill_fcnt", 32'(fcnt), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovr", 32'(ovr), 32'd1);
        chk("fill_txd", 32'(txd), 32'd1);
        @(negedge clk);
        clrerr = 1'b1;
        ie = 1'b1;
        @(negedge clk);
        clrerr = 1'b0;
        chk("clr_ovr", 32'(ovr), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);
        chk("clr_txd", 32'(txd), 32'd1);
        for (int i = 0; i < 4; i++) push_frame({1'b0, v5[i]}, 8, 2'b00, 1'b0);
        xcts = 1'b0;
        check_frame("burst", 0, 1, 40, -1);
        chk("burst_fcnt", 32'(fcnt), 32'd0);
        chk("burst_irq", 32'(irq), 32'd1);
        ie = 1'b0;

        // xCTS raised mid-frame: frame completes, next one is held
        baud = 16'd3;
        push_frame(9'h096, 8, 2'b00, 1'b0);
        wr(8'h96);
        wr(8'h69);
        check_frame("cts_f1", 0, 4, 10, 4);
        repeat (30) @(negedge clk);
        chk("cts_hold_txd", 32'(txd), 32'd1);
        chk("cts_hold_fcnt", 32'(fcnt), 32'd1);
        chk("cts_hold_idle", 32'(txidle), 32'd0);
        push_frame(9'h069, 8, 2'b00, 1'b0);
        xcts = 1'b0;
        check_frame("cts_f2", 0, 4, 10, -1);
        check_len("cts_f2_len", 40);
        ctsen = 1'b0;

        // RS-485 drive enable with guard time
        m485 = 1'b1; baud = 16'd1;
        push_frame(9'h03C, 8, 2'b00, 1'b0);
        wr(8'h3C);
        check_frame("rs485", 0, 2, 10, -1);
        chk("rs485_xde_start", 32'(xde_at_start), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (xde === 1'b0) seen = 1'b1;
        end
        chk("rs485_xde_len", seen ? 32'(cyc - start_cyc) : 32'hFFFF_FFFF, 32'd22);
        chk("rs485_txd_end", 32'(txd), 32'd1);
        chk("rs485_idle_end", 32'(txidle), 32'd1);
        m485 = 1'b0;

        // Depth 0, 9-bit: second write accepted once the holder is popped
        push_frame(9'h1FF, 9, 2'b00, 1'b0);
        push_frame(9'h000, 9, 2'b00, 1'b0);
        @(negedge clk);
        b_we = 1'b1;
        b_di = 9'h1FF;
        @(negedge clk);
        b_di = 9'h000;
        @(negedge clk);
        b_we = 1'b0;
        check_frame("d0w9", 1, 2, 22, -1);
        chk("d0w9_ovr", 32'(ovr9), 32'd0);
        chk("d0w9_fcnt", 32'(fcnt9), 32'd0);
        chk("d0w9_full", 32'(full9), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
